id_ex_stage: RTL
================

# id_ex_stage

Decode/issue pipeline stage between IF/ID and EX in the MIPS pipeline. It drives the register file read addresses from the incoming instruction and captures the operand data into registered ID/EX outputs. It also decodes destination, immediate and load class. It detects load-use hazards, inserts bubbles and honours downstream hold and branch flush.

## Interface
- REG_SIZE, 32, datapath width
- ADDRESS_WIDTH, 5, register address width
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- if_id_valid  in  1  IF/ID holds a real instruction
- if_id_instr  in  32  instruction word
- if_id_pc_plus4  in  32  PC+4 of the instruction
- reg_a_data_out  in  REG_SIZE  register file port A data
- reg_b_data_out  in  REG_SIZE  register file port B data
- read_reg_a_addr  out  ADDRESS_WIDTH  instr[25:21] (rs), combinational
- read_reg_b_addr  out  ADDRESS_WIDTH  instr[20:16] (rt), combinational
- wb_write_en  in  1  writeback writes this cycle
- wb_write_addr  in  ADDRESS_WIDTH  writeback destination
- wb_write_data  in  REG_SIZE  writeback data
- ex_hold  in  1  EX cannot accept; freeze stage
- flush  in  1  kill the contents of ID/EX
- stall  out  1  freeze PC and IF/ID, combinational
- ex_valid  out  1  ID/EX holds a real instruction
- ex_rs_data, ex_rt_data  out  REG_SIZE  captured operands
- ex_imm  out  32  extended immediate
- ex_rs_addr, ex_rt_addr, ex_dest  out  ADDRESS_WIDTH  source and destination registers
- ex_opcode, ex_funct  out  6  instr[31:26], instr[5:0]
- ex_is_load  out  1  instruction is a load
- ex_pc_plus4  out  32  captured PC+4

## Operation
- dest: opcode 0x00 → rd (instr[15:11]); 0x03 (jal) → 31; otherwise rt.
- is_load: opcode ∈ {0x20,0x21,0x23,0x24,0x25}.
- imm: zero-extend instr[15:0] for opcodes 0x0C/0x0D/0x0E; sign-extend otherwise.
- Operand select per port: address 0 → 0 always. Otherwise the bypass value (see Configuration). Otherwise the register file data.
- load_use = ex_valid & ex_is_load & ex_dest≠0 & if_id_valid & (ex_dest==rs | ex_dest==rt). The rt comparison is applied for every opcode (conservative).
- stall = ~flush & (ex_hold | load_use | wb_hazard). wb_hazard is defined under Configuration.
- Update priority at each edge:
  1. flush: ex_valid←0, other fields don't-care.
  2. ex_hold: all fields hold.
  3. load_use or wb_hazard: bubble, ex_valid←0.
  4. Otherwise capture: ex_valid←if_id_valid, all fields from decode.
- When if_id_valid=0, the fields still load but ex_valid=0. No hazard is raised from an invalid IF/ID.

## Timing
- Latency 1 cycle: decode/read in cycle N, ex_* valid after edge N.
- Reset (reset=0): all ex_* outputs 0 immediately. stall then depends only on ex_hold, wb_hazard and flush, since ex_valid=0.
- Reset released mid-stream: first capture at the first rising edge with reset=1.
- Load-use costs exactly one bubble. The next cycle ex_valid=0, so load_use clears and the instruction issues.
- Simultaneous flush and ex_hold: flush wins and the stage empties.
- Simultaneous flush and hazard: bubble; stall=0.
- read_reg_*_addr follow if_id_instr combinationally, including during stall.

## Configuration
- WB_BYPASS_EN defined:
  - If wb_write_en & wb_write_addr≠0 & wb_write_addr==source address, the operand takes wb_write_data (same-cycle write-before-read).
  - wb_hazard=0.
- WB_BYPASS_EN undefined:
  - No bypass mux.
  - wb_hazard = if_id_valid & wb_write_en & wb_write_addr≠0 & (wb_write_addr==rs | wb_write_addr==rt).
  - Produces one bubble; the operand is then read from the updated register file.

## Test plan
- Reset: reset=0 with instr 0x8C220004 presented → ex_valid=0, all ex_* 0, stall=0. Release reset → after one edge ex_valid=1, ex_dest=2, ex_is_load=1, ex_imm=0x00000004.
- Immediates: addi $1,$0,-1 (0x2001FFFF) → ex_imm=0xFFFFFFFF, ex_dest=1; ori $1,$0,0xFFFF (0x3401FFFF) → ex_imm=0x0000FFFF. R-type add $3,$1,$2 → ex_dest=3, ex_funct=0x20.
- Load-use: lw $2,0($1) followed by add $3,$2,$4 → stall=1 for one cycle, one ex_valid=0 bubble, then the add issues; total 2 edges for the add.
- WB bypass (macro on): rf port A returns 0x11, wb writes $5=0xAB same cycle, instr reads rs=$5 → ex_rs_data=0xAB, stall=0. Macro off → stall=1 for one cycle, then ex_rs_data comes from rf.
- $zero: instr reads $0 with rf returning 0xDEAD and a wb write to addr 0 pending → ex_rs_data=0.
- Hold/flush: ex_hold=1 for 3 cycles → ex_* unchanged, stall=1. flush=1 with ex_hold=1 → next edge ex_valid=0 and stall=0 that cycle.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: register-file addressing, decode, load-use / writeback hazard bubbles.
// Optional WB_BYPASS_EN: forward the same-cycle writeback value instead of stalling on it.
module id_ex_stage #(
    parameter int REG_SIZE      = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     if_id_valid,
    input  logic [31:0]              if_id_instr,
    input  logic [31:0]              if_id_pc_plus4,
    input  logic [REG_SIZE-1:0]      reg_a_data_out,
    input  logic [REG_SIZE-1:0]      reg_b_data_out,
    output logic [ADDRESS_WIDTH-1:0] read_reg_a_addr,
    output logic [ADDRESS_WIDTH-1:0] read_reg_b_addr,
    input  logic                     wb_write_en,
    input  logic [ADDRESS_WIDTH-1:0] wb_write_addr,
    input  logic [REG_SIZE-1:0]      wb_write_data,
    input  logic                     ex_hold,
    input  logic                     flush,
    output logic                     stall,
    output logic                     ex_valid,
    output logic [REG_SIZE-1:0]      ex_rs_data,
    output logic [REG_SIZE-1:0]      ex_rt_data,
    output logic [31:0]              ex_imm,
    output logic [ADDRESS_WIDTH-1:0] ex_rs_addr,
    output logic [ADDRESS_WIDTH-1:0] ex_rt_addr,
    output logic [ADDRESS_WIDTH-1:0] ex_dest,
    output logic [5:0]               ex_opcode,
    output logic [5:0]               ex_funct,
    output logic                     ex_is_load,
    output logic [31:0]              ex_pc_plus4
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;

    logic [5:0]               w_opcode;
    logic [5:0]               w_funct;
    logic [ADDRESS_WIDTH-1:0] w_rs;
    logic [ADDRESS_WIDTH-1:0] w_rt;
    logic [ADDRESS_WIDTH-1:0] w_rd;
    logic [ADDRESS_WIDTH-1:0] w_dest;
    logic                     w_is_load;
    logic [31:0]              w_imm;
    logic [REG_SIZE-1:0]      w_rs_data;
    logic [REG_SIZE-1:0]      w_rt_data;
    logic                     w_load_use;
    logic                     w_wb_hazard;

    logic                     r_ex_valid;
    logic [REG_SIZE-1:0]      r_ex_rs_data;
    logic [REG_SIZE-1:0]      r_ex_rt_data;
    logic [31:0]              r_ex_imm;
    logic [ADDRESS_WIDTH-1:0] r_ex_rs_addr;
    logic [ADDRESS_WIDTH-1:0] r_ex_rt_addr;
    logic [ADDRESS_WIDTH-1:0] r_ex_dest;
    logic [5:0]               r_ex_opcode;
    logic [5:0]               r_ex_funct;
    logic                     r_ex_is_load;
    logic [31:0]              r_ex_pc_plus4;

    assign w_opcode = if_id_instr[31:26];
    assign w_funct  = if_id_instr[5:0];
    assign w_rs     = ADDRESS_WIDTH'(if_id_instr[25:21]);
    assign w_rt     = ADDRESS_WIDTH'(if_id_instr[20:16]);
    assign w_rd     = ADDRESS_WIDTH'(if_id_instr[15:11]);

    assign read_reg_a_addr = w_rs;
    assign read_reg_b_addr = w_rt;

    always_comb begin
        w_dest    = w_rt;
        w_is_load = 1'b0;
        w_imm     = {{16{if_id_instr[15]}}, if_id_instr[15:0]};
        if (w_opcode == OP_RTYPE) begin
            w_dest = w_rd;
        end else if (w_opcode == OP_JAL) begin
            w_dest = ADDRESS_WIDTH'(31);
        end
        case (w_opcode)
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: w_is_load = 1'b1;
            default:                           w_is_load = 1'b0;
        endcase
        case (w_opcode)
            6'h0C, 6'h0D, 6'h0E: w_imm = {16'h0000, if_id_instr[15:0]};
            default:             w_imm = {{16{if_id_instr[15]}}, if_id_instr[15:0]};
        endcase
    end

`ifdef WB_BYPASS_EN
    always_comb begin
        w_rs_data   = reg_a_data_out;
        w_rt_data   = reg_b_data_out;
        w_wb_hazard = 1'b0;
        if (wb_write_en && (wb_write_addr != '0) && (wb_write_addr == w_rs)) begin
            w_rs_data = wb_write_data;
        end
        if (wb_write_en && (wb_write_addr != '0) && (wb_write_addr == w_rt)) begin
            w_rt_data = wb_write_data;
        end
        if (w_rs == '0) begin
            w_rs_data = '0;
        end
        if (w_rt == '0) begin
            w_rt_data = '0;
        end
    end
`else
    // Without the bypass, a pending write to a source costs one bubble; the
    // register file holds the new value by the time the instruction retries.
    logic w_unused_wb_data;
    assign w_unused_wb_data = ^wb_write_data;

    always_comb begin
        w_rs_data   = (w_rs == '0) ? '0 : reg_a_data_out;
        w_rt_data   = (w_rt == '0) ? '0 : reg_b_data_out;
        w_wb_hazard = if_id_valid && wb_write_en && (wb_write_addr != '0) &&
                      ((wb_write_addr == w_rs) || (wb_write_addr == w_rt));
    end
`endif

    // rt is compared for every opcode; a false hit only costs one bubble.
    assign w_load_use = r_ex_valid && r_ex_is_load && (r_ex_dest != '0) && if_id_valid &&
                        ((r_ex_dest == w_rs) || (r_ex_dest == w_rt));

    assign stall = !flush && (ex_hold || w_load_use || w_wb_hazard);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ex_valid    <= 1'b0;
            r_ex_rs_data  <= '0;
            r_ex_rt_data  <= '0;
            r_ex_imm      <= '0;
            r_ex_rs_addr  <= '0;
            r_ex_rt_addr  <= '0;
            r_ex_dest     <= '0;
            r_ex_opcode   <= '0;
            r_ex_funct    <= '0;
            r_ex_is_load  <= 1'b0;
            r_ex_pc_plus4 <= '0;
        end else if (flush) begin
            r_ex_valid <= 1'b0;
        end else if (ex_hold) begin
            r_ex_valid <= r_ex_valid;
        end else if (w_load_use || w_wb_hazard) begin
            r_ex_valid <= 1'b0;
        end else begin
            r_ex_valid    <= if_id_valid;
            r_ex_rs_data  <= w_rs_data;
            r_ex_rt_data  <= w_rt_data;
            r_ex_imm      <= w_imm;
            r_ex_rs_addr  <= w_rs;
            r_ex_rt_addr  <= w_rt;
            r_ex_dest     <= w_dest;
            r_ex_opcode   <= w_opcode;
            r_ex_funct    <= w_funct;
            r_ex_is_load  <= w_is_load;
            r_ex_pc_plus4 <= if_id_pc_plus4;
        end
    end

    assign ex_valid    = r_ex_valid;
    assign ex_rs_data  = r_ex_rs_data;
    assign ex_rt_data  = r_ex_rt_data;
    assign ex_imm      = r_ex_imm;
    assign ex_rs_addr  = r_ex_rs_addr;
    assign ex_rt_addr  = r_ex_rt_addr;
    assign ex_dest     = r_ex_dest;
    assign ex_opcode   = r_ex_opcode;
    assign ex_funct    = r_ex_funct;
    assign ex_is_load  = r_ex_is_load;
    assign ex_pc_plus4 = r_ex_pc_plus4;

endmodule
